// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the MM:SS clock mode controller.
//   mode_e      : front-panel mode encoding (STOP/RUN/SET)
//   SEL_*       : edit_sel codes for the digit under edit
//   TENS_MAX    : upper limit of min10/sec10 digits
//   UNITS_MAX   : upper limit of min01/sec01 digits
//   digit_inc() : wrapping digit increment (out-of-range values wrap to 0)
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_SET  = 2'b10
  } mode_e;

  localparam logic [1:0] SEL_MIN10 = 2'd3;
  localparam logic [1:0] SEL_MIN01 = 2'd2;
  localparam logic [1:0] SEL_SEC10 = 2'd1;
  localparam logic [1:0] SEL_SEC01 = 2'd0;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_tick_gen.sv
// tick_gen: 1 s prescaler for the clock mode controller.
//   Parameter TICK_DIV : CLK1 cycles per tick (>= 2)
//   CLK1, RESET        : clock, asynchronous active-high reset
//   en                 : prescaler count enable
//   clr                : synchronous clear of prescaler (and blink phase)
//   wrap               : high for the cycle the prescaler sits at TICK_DIV-1 while enabled
//   blink_phase        : (BLINK_EN only) 0 = "on", 1 = "off"; toggles every TICK_DIV/4 cycles
// Optional feature macro: BLINK_EN.
module tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLK1,
  input  logic RESET,
  input  logic en,
  input  logic clr,
`ifdef BLINK_EN
  output logic blink_phase,
`endif
  output logic wrap
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET)        cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign wrap = en && (cnt == LAST);

`ifdef BLINK_EN
  // Quarter-period divider kept separate from the main prescaler so the
  // blink phase can restart on edits without disturbing tick alignment logic.
  localparam int unsigned QDIV = (TICK_DIV / 4 > 0) ? TICK_DIV / 4 : 1;
  localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  logic [QW-1:0] qcnt;

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      qcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (clr) begin
      qcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (en) begin
      if (qcnt == QLAST) begin
        qcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: STOP/RUN/SET sequencer for the MM:SS time_counter datapath.
//   Parameter TICK_DIV : CLK1 cycles per 1 s tick (>= 2)
//   CLK1, RESET        : clock, asynchronous active-high reset
//   btn_start/mode/next/inc : 1-cycle button pulses (priority mode>start>next>inc)
//   cnt_min10..cnt_sec01    : next-time digits from time_counter
//   cur_min10..cur_sec01    : current time to counter inputs / display
//   cnt_enable, tick        : 1-cycle strobe at each 1 s boundary in RUN
//   mode                    : 00 STOP, 01 RUN, 10 SET
//   edit_sel                : digit under edit (3 min10 .. 0 sec01)
//   blink_mask              : per-digit blank request in SET
// Optional feature macro: BLINK_EN (digit blinking in SET; default build ties blink_mask to 0).
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLK1,
  input  logic       RESET,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [3:0] cnt_min10,
  input  logic [3:0] cnt_min01,
  input  logic [3:0] cnt_sec10,
  input  logic [3:0] cnt_sec01,
  output logic [3:0] cur_min10,
  output logic [3:0] cur_min01,
  output logic [3:0] cur_sec10,
  output logic [3:0] cur_sec01,
  output logic       cnt_enable,
  output logic [1:0] mode,
  output logic [1:0] edit_sel,
  output logic       tick,
  output logic [3:0] blink_mask
);

  mode_e       mode_q, mode_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] time_q, time_d;   // {min10, min01, sec10, sec01}
  logic [3:0]  lim;
  logic        pre_en, pre_clr, wrap;
  logic        do_mode, do_start, do_next, do_inc;

  assign do_mode  = btn_mode;
  assign do_start = btn_start & ~btn_mode;
  assign do_next  = btn_next  & ~btn_mode & ~btn_start;
  assign do_inc   = btn_inc   & ~btn_mode & ~btn_start & ~btn_next;

`ifdef BLINK_EN
  logic blink_phase;
  assign pre_en = (mode_q == MODE_RUN) || (mode_q == MODE_SET);
`else
  assign pre_en = (mode_q == MODE_RUN);
`endif

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLK1        (CLK1),
    .RESET       (RESET),
    .en          (pre_en),
    .clr         (pre_clr),
`ifdef BLINK_EN
    .blink_phase (blink_phase),
`endif
    .wrap        (wrap)
  );

  // The prescaler also runs in SET when blinking is built in, so the tick
  // must be qualified by RUN here rather than by the prescaler enable.
  assign tick       = wrap && (mode_q == MODE_RUN);
  assign cnt_enable = tick;

  always_comb begin
    mode_d  = mode_q;
    sel_d   = sel_q;
    time_d  = time_q;
    pre_clr = 1'b0;
    lim     = UNITS_MAX;
    // Capture is independent of the mode transition so a tick coinciding
    // with btn_start still lands the new time.
    if (cnt_enable) time_d = {cnt_min10, cnt_min01, cnt_sec10, cnt_sec01};
    case (sel_q)
      SEL_MIN10, SEL_SEC10: lim = TENS_MAX;
      SEL_MIN01, SEL_SEC01: lim = UNITS_MAX;
      default:              lim = UNITS_MAX;
    endcase
    case (mode_q)
      MODE_STOP: begin
        if (do_mode) begin
          mode_d  = MODE_SET;
          sel_d   = SEL_MIN10;
          pre_clr = 1'b1;
        end else if (do_start) begin
          mode_d  = MODE_RUN;
          pre_clr = 1'b1;
        end
      end
      MODE_RUN: begin
        if (do_start) mode_d = MODE_STOP;
      end
      MODE_SET: begin
        if (do_mode) begin
          mode_d = MODE_STOP;
        end else if (do_next) begin
          sel_d   = sel_q - 2'd1;   // 3->2->1->0->3 by natural 2-bit wrap
          pre_clr = 1'b1;
        end else if (do_inc) begin
          time_d[{sel_q, 2'b00} +: 4] = digit_inc(time_q[{sel_q, 2'b00} +: 4], lim);
          pre_clr = 1'b1;
        end
      end
      default: mode_d = MODE_STOP;
    endcase
  end

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      mode_q <= MODE_STOP;
      sel_q  <= SEL_MIN10;
      time_q <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      time_q <= time_d;
    end
  end

  assign mode      = mode_q;
  assign edit_sel  = sel_q;
  assign cur_min10 = time_q[15:12];
  assign cur_min01 = time_q[11:8];
  assign cur_sec10 = time_q[7:4];
  assign cur_sec01 = time_q[3:0];

`ifdef BLINK_EN
  assign blink_mask = ((mode_q == MODE_SET) && blink_phase) ? (4'b0001 << sel_q) : '0;
`else
  assign blink_mask = '0;
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl with TICK_DIV=4 and a behavioural
// time_counter (combinational next-time from cur_* and cnt_enable).
module tb_clock_mode_ctrl;

  localparam logic [1:0] M_STOP = 2'b00, M_RUN = 2'b01, M_SET = 2'b10;
  localparam logic [3:0] B_MODE = 4'b1000, B_START = 4'b0100, B_NEXT = 4'b0010, B_INC = 4'b0001;
  localparam logic [25:0] MK_MODE  = 26'h3000000;
  localparam logic [25:0] MK_EDIT  = 26'h0C00000;
  localparam logic [25:0] MK_CUR   = 26'h03FFFC0;
  localparam logic [25:0] MK_EN    = 26'h0000020;
  localparam logic [25:0] MK_TICK  = 26'h0000010;
  localparam logic [25:0] MK_BLINK = 26'h000000F;
  localparam logic [25:0] MK_ALL   = 26'h3FFFFFF;

  logic CLK1 = 1'b0;
  logic RESET = 1'b1;
  logic btn_start = 1'b0, btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
  logic [3:0] cnt_min10, cnt_min01, cnt_sec10, cnt_sec01;
  logic [3:0] cur_min10, cur_min01, cur_sec10, cur_sec01;
  logic cnt_enable, tick;
  logic [1:0] mode, edit_sel;
  logic [3:0] blink_mask;

  clock_mode_ctrl #(.TICK_DIV(4)) dut (
    .CLK1(CLK1), .RESET(RESET),
    .btn_start(btn_start), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .cnt_min10(cnt_min10), .cnt_min01(cnt_min01), .cnt_sec10(cnt_sec10), .cnt_sec01(cnt_sec01),
    .cur_min10(cur_min10), .cur_min01(cur_min01), .cur_sec10(cur_sec10), .cur_sec01(cur_sec01),
    .cnt_enable(cnt_enable), .mode(mode), .edit_sel(edit_sel), .tick(tick), .blink_mask(blink_mask)
  );

  always #5 CLK1 = ~CLK1;

  // Behavioural time_counter: seconds arithmetic modulo one hour.
  function automatic logic [15:0] next_time(input logic [15:0] t);
    int s;
    s = int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    s = (s + 1) % 3600;
    return {4'((s / 600) % 10), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  logic [15:0] cur_all, cnt_all;
  assign cur_all = {cur_min10, cur_min01, cur_sec10, cur_sec01};
  always_comb begin
    cnt_all = cnt_enable ? next_time(cur_all) : cur_all;
    {cnt_min10, cnt_min01, cnt_sec10, cnt_sec01} = cnt_all;
  end

  logic [25:0] snap;
  assign snap = {mode, edit_sel, cur_all, cnt_enable, tick, blink_mask};

  typedef struct {
    int          at;
    string       nm;
    logic [25:0] msk;
    logic [25:0] val;
  } exp_t;

  exp_t sq[$];
  int   tq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge CLK1) cyc <= cyc + 1;

  function automatic logic [15:0] tm(input int a, input int b, input int c, input int d);
    return {4'(a), 4'(b), 4'(c), 4'(d)};
  endfunction

  function automatic logic [25:0] mk(input logic [1:0] m, input logic [1:0] e, input logic [15:0] t,
                                     input logic en, input logic tk, input logic [3:0] bl);
    return {m, e, t, en, tk, bl};
  endfunction

  task automatic push_exp(input int at, input string nm, input logic [25:0] msk, input logic [25:0] val);
    exp_t e;
    int   i;
    e.at = at; e.nm = nm; e.msk = msk; e.val = val;
    i = sq.size();
    while (i > 0 && sq[i-1].at > at) i--;
    sq.insert(i, e);
  endtask

  task automatic exp_state(input int at, input string nm, input logic [1:0] m, input logic [1:0] e,
                           input logic [15:0] t);
    push_exp(at, nm, MK_MODE | MK_EDIT | MK_CUR, mk(m, e, t, 1'b0, 1'b0, 4'h0));
  endtask

  // Scoreboard monitor: state expectations by cycle, plus one entry per cnt_enable pulse.
  always @(negedge CLK1) begin
    exp_t e;
    int   t;
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      e = sq.pop_front();
      checks++;
      if (e.at != cyc || (snap & e.msk) !== e.val) begin
        errors++;
        $display("FAIL %s cycle %0d (due %0d): got %h want %h (mask %h)",
                 e.nm, cyc, e.at, snap & e.msk, e.val, e.msk);
      end
    end
    if (cnt_enable === 1'b1) begin
      checks++;
      if (tq.size() == 0) begin
        errors++;
        $display("FAIL cnt_enable_unexpected cycle %0d: got pulse want none", cyc);
      end else begin
        t = tq.pop_front();
        if (t != cyc || tick !== 1'b1) begin
          errors++;
          $display("FAIL cnt_enable_pulse: got cycle %0d tick %b want cycle %0d tick 1", cyc, tick, t);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    {btn_mode, btn_start, btn_next, btn_inc} = b;
    step();
    {btn_mode, btn_start, btn_next, btn_inc} = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s, p;
    int m10_seq[7] = '{1, 2, 3, 4, 5, 0, 1};

    step(); step();
    RESET = 1'b0;
    push_exp(cyc, "reset_state", MK_ALL, mk(M_STOP, 2'd3, 16'h0000, 1'b0, 1'b0, 4'h0));
    step();

    // RUN from 00:00: enable every 4th cycle, capture visible the cycle after.
    press(B_START);
    s = cyc;
    exp_state(s, "run_enter", M_RUN, 2'd3, 16'h0000);
    push_exp(s, "run_no_en", MK_EN | MK_TICK, 26'h0);
    tq.push_back(s + 3);
    tq.push_back(s + 7);
    push_exp(s + 3, "pre_tick1", MK_CUR, {2'b0, 2'b0, 16'h0000, 6'b0});
    push_exp(s + 4, "tick1_cur", MK_CUR, {2'b0, 2'b0, 16'h0001, 6'b0});
    push_exp(s + 7, "pre_tick2", MK_CUR, {2'b0, 2'b0, 16'h0001, 6'b0});
    push_exp(s + 8, "tick2_cur", MK_CUR, {2'b0, 2'b0, 16'h0002, 6'b0});
    repeat (10) step();
    press(B_START);
    exp_state(cyc, "run_to_stop", M_STOP, 2'd3, 16'h0002);

    // Priority: mode beats start in STOP; start ignored in SET.
    press(B_MODE | B_START);
    exp_state(cyc, "mode_over_start", M_SET, 2'd3, 16'h0002);
    press(B_START);
    exp_state(cyc, "start_in_set", M_SET, 2'd3, 16'h0002);
`ifndef BLINK_EN
    push_exp(cyc, "blink_tied_0", MK_BLINK, 26'h0);
`endif

    // Digit editing with wrap.
    for (int i = 0; i < 7; i++) begin
      press(B_INC);
      exp_state(cyc, "min10_inc", M_SET, 2'd3, tm(m10_seq[i], 0, 0, 2));
    end
    press(B_NEXT);
    exp_state(cyc, "next_to_min01", M_SET, 2'd2, tm(1, 0, 0, 2));
    for (int i = 0; i < 10; i++) begin
      press(B_INC);
      exp_state(cyc, "min01_inc", M_SET, 2'd2, tm(1, (i + 1) % 10, 0, 2));
    end
    repeat (9) press(B_INC);
    exp_state(cyc, "min01_nine", M_SET, 2'd2, tm(1, 9, 0, 2));
    press(B_NEXT);
    p = cyc;
    exp_state(p, "next_to_sec10", M_SET, 2'd1, tm(1, 9, 0, 2));
`ifdef BLINK_EN
    push_exp(p,     "blink_on0",  MK_BLINK, 26'h0);
    push_exp(p + 1, "blink_off0", MK_BLINK, 26'h2);
    push_exp(p + 2, "blink_on1",  MK_BLINK, 26'h0);
    push_exp(p + 3, "blink_off1", MK_BLINK, 26'h2);
`else
    push_exp(p + 1, "blink_idle", MK_BLINK, 26'h0);
`endif
    repeat (4) step();
    repeat (5) press(B_INC);
    exp_state(cyc, "sec10_five", M_SET, 2'd1, tm(1, 9, 5, 2));
    press(B_NEXT);
    repeat (7) press(B_INC);
    exp_state(cyc, "sec01_nine", M_SET, 2'd0, tm(1, 9, 5, 9));
    press(B_NEXT);
    exp_state(cyc, "next_wrap_3", M_SET, 2'd3, tm(1, 9, 5, 9));
    repeat (4) press(B_INC);
    exp_state(cyc, "set_5959", M_SET, 2'd3, tm(5, 9, 5, 9));
    press(B_MODE);
    exp_state(cyc, "set_to_stop", M_STOP, 2'd3, tm(5, 9, 5, 9));
    push_exp(cyc, "stop_blink0", MK_BLINK, 26'h0);

    // 59:59 wraps to 00:00; stop pressed on the tick cycle still captures.
    press(B_START);
    s = cyc;
    exp_state(s, "run_5959", M_RUN, 2'd3, tm(5, 9, 5, 9));
    tq.push_back(s + 3);
    push_exp(s + 3, "pre_wrap", MK_CUR, {2'b0, 2'b0, tm(5, 9, 5, 9), 6'b0});
    push_exp(s + 3, "tick_hi", MK_EN | MK_TICK, 26'h30);
    exp_state(s + 4, "wrap_and_stop", M_STOP, 2'd3, 16'h0000);
    push_exp(s + 4, "en_lo_after", MK_EN | MK_TICK, 26'h0);
    repeat (3) step();
    press(B_START);
    repeat (5) step();

    // Async reset in the middle of a run at 12:34.
    press(B_MODE);
    press(B_INC);
    press(B_NEXT); repeat (2) press(B_INC);
    press(B_NEXT); repeat (3) press(B_INC);
    press(B_NEXT); repeat (4) press(B_INC);
    exp_state(cyc, "set_1234", M_SET, 2'd0, 16'h1234);
    press(B_MODE);
    press(B_START);
    exp_state(cyc, "run_1234", M_RUN, 2'd0, 16'h1234);
    step();
    RESET = 1'b1;
    push_exp(cyc, "async_reset", MK_ALL, mk(M_STOP, 2'd3, 16'h0000, 1'b0, 1'b0, 4'h0));
    step(); step();
    RESET = 1'b0;
    push_exp(cyc, "post_reset", MK_ALL, mk(M_STOP, 2'd3, 16'h0000, 1'b0, 1'b0, 4'h0));
    repeat (6) step();

    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sq.size());
    end
    checks++;
    if (tq.size() != 0) begin
      errors++;
      $display("FAIL cnt_enable_missing: got %0d unseen pulses want 0", tq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
